// File: rtl/arb_mux_if.sv
// arb_mux_if: bundles the N request channels, the shared output channel and the
// arbitration mode of an arb_mux into one interface.
//   mode              0 = fixed priority, 1 = round-robin
//   in_valid/in_ready per-channel handshake, channel i data at in_data[i*WIDTH +: WIDTH]
//   out_valid/out_ready output handshake, out_data word, out_sel source channel
// Modports: master = requesters/consumer side, slave = the arbiter itself.
interface arb_mux_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
);
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

    logic                 mode;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
    logic                 out_ready;

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/arb_mux.sv
// arb_mux: registered N-to-1 arbitrating multiplexer with valid/ready on every
// channel. A fixed-priority or round-robin arbiter picks one requester whenever
// the one-entry output register is empty or being drained, and the winner's word
// and index are captured into that register.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  arb_mux_if.slave (mode, in_valid/in_data/in_ready, out_valid/out_data/
//        out_sel/out_ready)
module arb_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
) (
    input  logic      clk,
    input  logic      rst,
    arb_mux_if.slave  bus
);
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW   = SELW + 1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q, out_sel_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load;
    logic             grant_found;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SELW:0]    rr_cand;

    // The register can take a new word when empty or when its word leaves this cycle.
    assign load = !out_valid_q || bus.out_ready;

    // Arbiter. Loops run from the far end so the lowest offset wins last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_cand     = '0;
        if (!bus.mode) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (bus.in_valid[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = SELW'(i);
                end
            end
        end else begin
            for (int k = int'(N) - 1; k >= 0; k--) begin
                // ptr + k modulo N, never wrapping through indices >= N
                rr_cand = {1'b0, ptr_q} + CW'(k);
                if (rr_cand >= CW'(N)) begin
                    rr_cand = rr_cand - CW'(N);
                end
                if (bus.in_valid[rr_cand[SELW-1:0]]) begin
                    grant_found = 1'b1;
                    grant_idx   = rr_cand[SELW-1:0];
                end
            end
        end
    end

    // Data select by constant slices only, so unselected channels cannot leak through.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = grant_found;
            if (grant_found) begin
                out_data_d = grant_data;
                out_sel_d  = grant_idx;
                ptr_d      = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    // Handshake is suppressed during reset so no word is lost to a discarded capture.
    always_comb begin
        bus.in_ready = '0;
        if (load && !rst && grant_found) begin
            bus.in_ready = N'(1) << grant_idx;
        end
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        bus.out_sel   = out_sel_q;
    end
endmodule

// File: tb/tb_arb_mux.sv
module tb_arb_mux;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arb_mux_if #(.WIDTH(W), .N(4)) if4 ();
    arb_mux_if #(.WIDTH(W), .N(3)) if3 ();

    arb_mux #(.WIDTH(W), .N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    arb_mux #(.WIDTH(W), .N(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    int n_cmp = 0;
    int n_fail = 0;

    // Stimulus state: index 0 drives the N=4 instance, index 1 the N=3 instance.
    logic          mode;
    logic [15:0]   vld [2];
    logic [W-1:0]  chan [2][16];
    logic          ordy [2];

    // Reference model state
    logic          mv [2];
    logic [W-1:0]  mdat [2];
    int            msel [2];
    int            mptr [2];

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    // First requester found when scanning from the start point, wrapping modulo n.
    function automatic int pick(input int n, input logic md, input logic [15:0] v, input int p);
        int start;
        start = md ? p : 0;
        for (int k = 0; k < n; k++) begin
            if (v[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [15:0] exp_ready(input int d);
        int g;
        if (rst || !(!mv[d] || ordy[d])) return 16'h0;
        g = pick(nch(d), mode, vld[d], mptr[d]);
        if (g < 0) return 16'h0;
        return 16'h1 << g;
    endfunction

    task automatic model_step(input int d);
        int n, g;
        n = nch(d);
        if (rst) begin
            mv[d] = 1'b0; mdat[d] = '0; msel[d] = 0; mptr[d] = 0;
        end else if (!mv[d] || ordy[d]) begin
            g = pick(n, mode, vld[d], mptr[d]);
            if (g >= 0) begin
                mv[d] = 1'b1; mdat[d] = chan[d][g]; msel[d] = g; mptr[d] = (g + 1) % n;
            end else begin
                mv[d] = 1'b0;
            end
        end
    endtask

    task automatic drive();
        if4.mode = mode;
        if3.mode = mode;
        if4.in_valid = vld[0][3:0];
        if3.in_valid = vld[1][2:0];
        for (int i = 0; i < 4; i++) if4.in_data[i*W +: W] = chan[0][i];
        for (int i = 0; i < 3; i++) if3.in_data[i*W +: W] = chan[1][i];
        if4.out_ready = ordy[0];
        if3.out_ready = ordy[1];
    endtask

    // One clock edge; the model follows on the same edge.
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive();
        tick();
        rst = 1'b0;
        drive();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mode = 1'b1;
        for (int d = 0; d < 2; d++) begin
            vld[d] = 16'hFFFF; ordy[d] = 1'b1;
            for (int i = 0; i < 16; i++) chan[d][i] = $urandom;
        end
        drive();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (if4.in_ready !== 4'b0) begin
                n_fail++; $display("FAIL reset_in_ready4 got %b want 0000", if4.in_ready);
            end
            n_cmp++;
            if (if3.in_ready !== 3'b0) begin
                n_fail++; $display("FAIL reset_in_ready3 got %b want 000", if3.in_ready);
            end
            tick();
        end
        rst = 1'b0;
        drive();
        @(negedge clk);
        n_cmp++;
        if (if4.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", if4.out_valid);
        end
        n_cmp++;
        if (if4.out_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_out_data got %h want 0", if4.out_data);
        end
        n_cmp++;
        if (if4.out_sel !== 2'd0) begin
            n_fail++; $display("FAIL reset_out_sel got %0d want 0", if4.out_sel);
        end
        n_cmp++;
        if (if4.in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_grant got %b want 0001", if4.in_ready);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (if4.out_valid !== 1'b1 || if4.out_sel !== 2'd0 || if4.out_data !== chan[0][0]) begin
            n_fail++;
            $display("FAIL reset_first_word got v=%b sel=%0d data=%h want v=1 sel=0 data=%h",
                     if4.out_valid, if4.out_sel, if4.out_data, chan[0][0]);
        end
    endtask

    task automatic test_fixed();
        mode = 1'b0;
        vld[0] = 16'b1010;
        ordy[0] = 1'b1;
        drive();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c > 0) begin
                n_cmp++;
                if (if4.out_valid !== 1'b1 || if4.out_sel !== 2'd1 ||
                    if4.out_data !== chan[0][1]) begin
                    n_fail++;
                    $display("FAIL fixed_out c=%0d got v=%b sel=%0d data=%h want v=1 sel=1 data=%h",
                             c, if4.out_valid, if4.out_sel, if4.out_data, chan[0][1]);
                end
            end
            n_cmp++;
            if (if4.in_ready !== 4'b0010) begin
                n_fail++; $display("FAIL fixed_ready c=%0d got %b want 0010", c, if4.in_ready);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        mode = 1'b1;
        vld[0] = 16'hF;
        ordy[0] = 1'b1;
        for (int i = 0; i < 4; i++) chan[0][i] = 32'h1000_0000 + i;
        drive();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c > 0) begin
                n_cmp++;
                if (if4.out_valid !== 1'b1 || {30'b0, if4.out_sel} !== (c - 1) % 4 ||
                    if4.out_data !== 32'h1000_0000 + (c - 1) % 4) begin
                    n_fail++;
                    $display("FAIL rr_out c=%0d got v=%b sel=%0d data=%h want v=1 sel=%0d",
                             c, if4.out_valid, if4.out_sel, if4.out_data, (c - 1) % 4);
                end
            end
            n_cmp++;
            if ({12'b0, if4.in_ready} !== 16'h1 << (c % 4)) begin
                n_fail++;
                $display("FAIL rr_ready c=%0d got %b want one-hot %0d", c, if4.in_ready, c % 4);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b0;
        vld[0] = 16'b0100;
        chan[0][2] = 32'hDEAD_BEEF;
        ordy[0] = 1'b1;
        drive();
        tick();
        ordy[0] = 1'b0;
        vld[0] = 16'hF;
        chan[0][0] = 32'h0000_0005;
        drive();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (if4.in_ready !== 4'b0 || if4.out_valid !== 1'b1 ||
                if4.out_data !== 32'hDEAD_BEEF || if4.out_sel !== 2'd2) begin
                n_fail++;
                $display("FAIL bp_hold c=%0d got rdy=%b v=%b data=%h sel=%0d want 0000 1 deadbeef 2",
                         c, if4.in_ready, if4.out_valid, if4.out_data, if4.out_sel);
            end
            tick();
        end
        ordy[0] = 1'b1;
        vld[0] = 16'b0001;
        drive();
        @(negedge clk);
        n_cmp++;
        if (if4.in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL bp_regrant got %b want 0001", if4.in_ready);
        end
        tick();
        vld[0] = 16'h0;
        drive();
        @(negedge clk);
        n_cmp++;
        if (if4.out_valid !== 1'b1 || if4.out_sel !== 2'd0 || if4.out_data !== 32'h5 ||
            if4.in_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL bp_refill got v=%b sel=%0d data=%h rdy=%b want 1 0 00000005 0000",
                     if4.out_valid, if4.out_sel, if4.out_data, if4.in_ready);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (if4.out_valid !== 1'b0 || if4.out_data !== 32'h5) begin
            n_fail++;
            $display("FAIL bp_drain got v=%b data=%h want v=0 data=00000005",
                     if4.out_valid, if4.out_data);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        mode = 1'b1;
        vld[1] = 16'b101;
        ordy[1] = 1'b1;
        for (int i = 0; i < 3; i++) chan[1][i] = $urandom;
        drive();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c > 0) begin
                n_cmp++;
                if (if3.out_valid !== 1'b1 ||
                    {30'b0, if3.out_sel} !== (((c - 1) % 2 == 0) ? 0 : 2) ||
                    if3.out_data !== chan[1][((c - 1) % 2 == 0) ? 0 : 2]) begin
                    n_fail++;
                    $display("FAIL wrap_out c=%0d got v=%b sel=%0d want sel=%0d",
                             c, if3.out_valid, if3.out_sel, ((c - 1) % 2 == 0) ? 0 : 2);
                end
            end
            n_cmp++;
            if (if3.in_ready !== ((c % 2 == 0) ? 3'b001 : 3'b100)) begin
                n_fail++;
                $display("FAIL wrap_ready c=%0d got %b want %b", c, if3.in_ready,
                         (c % 2 == 0) ? 3'b001 : 3'b100);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        mode = 1'b1;
        vld[0] = 16'hF;
        ordy[0] = 1'b1;
        drive();
        tick();
        tick();
        ordy[0] = 1'b0;
        drive();
        @(negedge clk);
        n_cmp++;
        if (if4.out_valid !== 1'b1 || if4.out_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL midrst_pre got v=%b sel=%0d want v=1 sel=1", if4.out_valid, if4.out_sel);
        end
        rst = 1'b1;
        ordy[0] = 1'b1;
        drive();
        #1;
        n_cmp++;
        if (if4.in_ready !== 4'b0) begin
            n_fail++; $display("FAIL midrst_ready got %b want 0000", if4.in_ready);
        end
        tick();
        rst = 1'b0;
        drive();
        @(negedge clk);
        n_cmp++;
        if (if4.out_valid !== 1'b0 || if4.out_sel !== 2'd0 || if4.out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_state got v=%b sel=%0d data=%h want 0 0 0",
                     if4.out_valid, if4.out_sel, if4.out_data);
        end
        n_cmp++;
        if (if4.in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL midrst_ptr got %b want 0001", if4.in_ready);
        end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] act_rdy;
        logic        act_v;
        logic [W-1:0] act_d;
        int          act_s;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            if (c % 25 == 0) mode = 1'($urandom);
            for (int d = 0; d < 2; d++) begin
                vld[d] = 16'($urandom);
                ordy[d] = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 16; i++) chan[d][i] = $urandom;
            end
            drive();
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    act_rdy = {12'b0, if4.in_ready}; act_v = if4.out_valid;
                    act_d = if4.out_data; act_s = {30'b0, if4.out_sel};
                end else begin
                    act_rdy = {13'b0, if3.in_ready}; act_v = if3.out_valid;
                    act_d = if3.out_data; act_s = {30'b0, if3.out_sel};
                end
                n_cmp++;
                if (act_rdy !== exp_ready(d)) begin
                    n_fail++;
                    $display("FAIL rand_ready n=%0d c=%0d got %h want %h",
                             nch(d), c, act_rdy, exp_ready(d));
                end
                n_cmp++;
                if (act_v !== mv[d] || act_d !== mdat[d] || act_s !== msel[d]) begin
                    n_fail++;
                    $display("FAIL rand_out n=%0d c=%0d got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                             nch(d), c, act_v, act_d, act_s, mv[d], mdat[d], msel[d]);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        mode = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; mdat[d] = '0; msel[d] = 0; mptr[d] = 0;
            vld[d] = '0; ordy[d] = 1'b0;
            for (int i = 0; i < 16; i++) chan[d][i] = '0;
        end
        drive();
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
